pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register for the MIPS core: the next generation of the fixed-field inter-stage registers. It carries a control field and a data field between pipeline stages behind a valid/ready handshake, and uses a 2-entry skid buffer so there is no combinational path from out_ready to in_ready. It adds synchronous flush, i.e. bubble insertion for branch/jump squash and hazard handling. While the stage is empty, the control field is forced to a NOP value, so downstream stages never act on stale control bits.

Parameters:
CTRL_W, 10, width of control field (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, jump, ALUOp).
DATA_W, 128, width of data field (operands, immediates, register indices, funct, opcode, concatenated).
NOP_CTRL, {CTRL_W{1'b0}}, control value presented whenever the stage holds no valid beat.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept a beat this cycle
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream data field
out_valid  output  1  output beat present
out_ready  input  1  downstream accepts output beat
out_ctrl  output  CTRL_W  output control field (NOP_CTRL when out_valid=0)
out_data  output  DATA_W  output data field
flush  input  1  synchronous squash of all held and incoming beats
occupancy  output  2  number of valid entries held (0..2)

Behaviour:
- Storage: main entry (drives out_*) and skid entry, each with a valid bit (main_v, skid_v).
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = ~skid_v. It is purely state-derived, with no combinational path from out_ready or in_valid.
- out_valid = main_v; occupancy = main_v + skid_v; skid_v=1 implies main_v=1.
- Reset (rst=0, async): main_v=0, skid_v=0, out_ctrl=NOP_CTRL, out_data=0, skid contents=0. Therefore out_valid=0, in_ready=1, occupancy=0, immediately and for the whole reset.
- Reset asserted mid-transfer drops all held beats; no beat survives reset.
- State transitions (flush=0):
  EMPTY (0,0): accept -> main<=in, go ONE; otherwise hold.
  ONE (1,0): accept & consume -> main<=in, stay ONE. Consume only -> main_v<=0, out_ctrl<=NOP_CTRL, out_data held, go EMPTY. Accept only -> skid<=in, go FULL. Neither -> hold.
  FULL (1,1): in_ready=0, so no accept. Consume -> main<=skid, skid_v<=0, go ONE. Otherwise hold.
- Latency: 1 cycle from accept (EMPTY state) to out_valid. Throughput 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO; a skid beat is always output before any later beat.
- Stall: out_ready=0 holds out_ctrl/out_data stable while out_valid=1 (no change until consume).
- Flush=1 (highest priority over accept/consume):
  - Next edge: main_v=0, skid_v=0, out_ctrl=NOP_CTRL; out_data and skid data are held.
  - Any beat accepted in the flush cycle is discarded.
  - A consume in the flush cycle still counts downstream; the stage does not re-present it.
- Flush held for several cycles: stage stays EMPTY with in_ready=1, and every beat offered is discarded.
- Invariant: out_valid=0 implies out_ctrl==NOP_CTRL at all times after any edge or reset.
- in_ctrl/in_data are sampled only on accept. Values while in_valid=0 never propagate.

Test Plan:
- Reset: rst=0 with in_valid=1, in_ctrl=10'h3FF -> out_valid=0, out_ctrl=NOP_CTRL, out_data=0, in_ready=1, occupancy=0. Release rst -> first accept appears 1 cycle later.
- Streaming: out_ready=1, 8 beats data=1..8 back-to-back -> out_data=1..8 on consecutive cycles, in_ready constantly 1, occupancy never exceeds 1.
- Backpressure: stream data=1..4, drop out_ready for 3 cycles after beat 1 is presented -> beat 2 captured in skid, in_ready=0, occupancy=2, out_data stays 1. Raise out_ready -> outputs 1,2,3,4 in order, none lost or duplicated.
- Flush while FULL: occupancy=2, assert flush with in_valid=1, data=9 -> next cycle out_valid=0, out_ctrl=NOP_CTRL, occupancy=0, beat 9 never appears at output.
- Drain to empty: single beat ctrl=10'h155 consumed -> next cycle out_valid=0 and out_ctrl=NOP_CTRL, out_data still equals last beat.
- Async reset mid-stall: occupancy=2, pulse rst low between edges -> outputs go to reset values without waiting for clk; random valid/ready soak checks FIFO order against a scoreboard.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and synchronous flush.
// in_ready depends only on stored state; an empty stage always presents NOP_CTRL.
module pipe_stage_skid #(
   parameter int                 CTRL_W   = 10,
   parameter int                 DATA_W   = 128,
   parameter logic [CTRL_W-1:0]  NOP_CTRL = {CTRL_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy
);

   // State encoding is {main_v, skid_v}, so the valid bits fall straight out of it.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t state, state_next;

   logic              main_v, skid_v;
   logic              accept, consume;
   logic              load_main_in, load_main_skid, load_skid, clear_main;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;

   assign main_v    = state[1];
   assign skid_v    = state[0];
   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign accept    = in_valid & in_ready;
   assign consume   = main_v & out_ready;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;

   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clear_main     = 1'b0;
      if (flush) begin
         state_next = EMPTY;
         clear_main = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_main_in = 1'b1;
                  state_next   = ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  load_main_in = 1'b1;
               end else if (consume) begin
                  clear_main = 1'b1;
                  state_next = EMPTY;
               end else if (accept) begin
                  load_skid  = 1'b1;
                  state_next = FULL;
               end
            end
            FULL: begin
               if (consume) begin
                  load_main_skid = 1'b1;
                  state_next     = ONE;
               end
            end
            default: begin
               state_next = EMPTY;
               clear_main = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Clearing main only forces the control field; data is left as-is on drain and flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_ctrl <= NOP_CTRL;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         if (clear_main) begin
            main_ctrl <= NOP_CTRL;
         end else if (load_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
         end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, hand-written
// corner sequences (reset, streaming, async reset during stall) and a random soak.
module tb_pipe_stage_skid;

   localparam int CTRL_W = 10;
   localparam int DATA_W = 128;
   localparam logic [CTRL_W-1:0] NOP = '0;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic              flush;
   logic [1:0]        occupancy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic              iv;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
      logic              ordy;
      logic              fl;
      logic              e_ov;
      logic [CTRL_W-1:0] e_ctrl;
      logic [DATA_W-1:0] e_data;
      logic              e_ir;
      logic [1:0]        e_occ;
   } vec_t;

   vec_t vecs[$];
   logic [CTRL_W+DATA_W-1:0] sb[$];

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOP_CTRL(NOP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, take the rising edge, then settle before sampling.
   task automatic applyStimulus(input logic iv, input logic [CTRL_W-1:0] c,
                                input logic [DATA_W-1:0] d, input logic ordy,
                                input logic fl);
      in_valid  = iv;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic checkState(input string tag, input logic ov, input logic [CTRL_W-1:0] c,
                             input logic [DATA_W-1:0] d, input logic ir, input logic [1:0] occ);
      checkOutput({tag, ".out_valid"}, DATA_W'(out_valid), DATA_W'(ov));
      checkOutput({tag, ".out_ctrl"},  DATA_W'(out_ctrl),  DATA_W'(c));
      checkOutput({tag, ".out_data"},  out_data, d);
      checkOutput({tag, ".in_ready"},  DATA_W'(in_ready),  DATA_W'(ir));
      checkOutput({tag, ".occupancy"}, DATA_W'(occupancy), DATA_W'(occ));
   endtask

   function automatic vec_t mk(logic iv, logic [CTRL_W-1:0] c, logic [DATA_W-1:0] d,
                               logic ordy, logic fl, logic ov, logic [CTRL_W-1:0] ec,
                               logic [DATA_W-1:0] ed, logic ir, logic [1:0] occ);
      vec_t v;
      v.iv = iv; v.ctrl = c; v.data = d; v.ordy = ordy; v.fl = fl;
      v.e_ov = ov; v.e_ctrl = ec; v.e_data = ed; v.e_ir = ir; v.e_occ = occ;
      return v;
   endfunction

   initial begin
      // Directed table: each row is one cycle of inputs and the state expected after its edge.
      vecs.push_back(mk(1, 10'h101, 1,     1, 0,  1, 10'h101, 1, 1, 1));
      vecs.push_back(mk(1, 10'h102, 2,     1, 0,  1, 10'h102, 2, 1, 1));
      vecs.push_back(mk(1, 10'h103, 3,     0, 0,  1, 10'h102, 2, 0, 2));
      vecs.push_back(mk(1, 10'h104, 4,     0, 0,  1, 10'h102, 2, 0, 2));
      vecs.push_back(mk(1, 10'h104, 4,     1, 0,  1, 10'h103, 3, 1, 1));
      vecs.push_back(mk(1, 10'h155, 4,     1, 0,  1, 10'h155, 4, 1, 1));
      vecs.push_back(mk(0, 10'h000, 0,     1, 0,  0, NOP,     4, 1, 0));
      vecs.push_back(mk(0, 10'h3FF, 'h55,  1, 0,  0, NOP,     4, 1, 0));
      vecs.push_back(mk(1, 10'h105, 5,     0, 0,  1, 10'h105, 5, 1, 1));
      vecs.push_back(mk(1, 10'h106, 6,     0, 0,  1, 10'h105, 5, 0, 2));
      vecs.push_back(mk(1, 10'h109, 9,     0, 1,  0, NOP,     5, 1, 0));
      vecs.push_back(mk(1, 10'h107, 7,     1, 1,  0, NOP,     5, 1, 0));
      vecs.push_back(mk(1, 10'h108, 8,     1, 0,  1, 10'h108, 8, 1, 1));
      vecs.push_back(mk(0, 10'h000, 0,     0, 0,  1, 10'h108, 8, 1, 1));
      vecs.push_back(mk(0, 10'h000, 0,     1, 1,  0, NOP,     8, 1, 0));

      // Reset with a beat offered: outputs at reset values before and after an edge.
      rst = 1'b0; in_valid = 1'b1; in_ctrl = 10'h3FF; in_data = 'hABC;
      out_ready = 1'b0; flush = 1'b0;
      #2;
      checkState("reset_pre_edge", 0, NOP, 0, 1, 0);
      @(posedge clk); #1;
      checkState("reset_post_edge", 0, NOP, 0, 1, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      applyStimulus(1, 10'h1AA, 'h77, 0, 0);
      checkState("first_accept", 1, 10'h1AA, 'h77, 1, 1);
      applyStimulus(0, 0, 0, 1, 0);
      checkState("first_drain", 0, NOP, 'h77, 1, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].iv, vecs[i].ctrl, vecs[i].data, vecs[i].ordy, vecs[i].fl);
         checkState($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ctrl, vecs[i].e_data,
                    vecs[i].e_ir, vecs[i].e_occ);
      end

      // Back-to-back streaming: one beat per cycle, never more than one held.
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1, CTRL_W'(10'h200 + i), DATA_W'(i), 1, 0);
         checkState($sformatf("stream%0d", i), 1, CTRL_W'(10'h200 + i), DATA_W'(i), 1, 1);
      end
      applyStimulus(0, 0, 0, 1, 0);
      checkState("stream_drain", 0, NOP, 8, 1, 0);

      // Fill to FULL, then pulse reset between edges and look before the next edge.
      applyStimulus(1, 10'h0A1, 'hA1, 0, 0);
      applyStimulus(1, 10'h0A2, 'hA2, 0, 0);
      checkState("stall_full", 1, 10'h0A1, 'hA1, 0, 2);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checkState("async_reset", 0, NOP, 0, 1, 0);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      checkState("after_async_reset", 0, NOP, 0, 1, 0);

      // Random soak against a FIFO scoreboard.
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_ctrl   = CTRL_W'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         flush     = 1'b0;
         #1;
         checkOutput("soak_occupancy", DATA_W'(occupancy), DATA_W'(sb.size()));
         if (!out_valid) checkOutput("soak_nop_ctrl", DATA_W'(out_ctrl), DATA_W'(NOP));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("soak_unexpected_beat", 1, 0);
            end else begin
               logic [CTRL_W+DATA_W-1:0] e;
               e = sb.pop_front();
               checkOutput("soak_ctrl", DATA_W'(out_ctrl), DATA_W'(e[CTRL_W+DATA_W-1:DATA_W]));
               checkOutput("soak_data", out_data, e[DATA_W-1:0]);
            end
         end
         if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
         @(posedge clk); #1;
      end

      // Bounded drain of whatever the soak left behind.
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 10 && sb.size() != 0; k++) begin
         if (out_valid) begin
            logic [CTRL_W+DATA_W-1:0] e;
            e = sb.pop_front();
            checkOutput("drain_data", out_data, e[DATA_W-1:0]);
         end
         @(posedge clk); #1;
      end
      checkOutput("drain_scoreboard_empty", DATA_W'(sb.size()), 0);
      checkState("drain_final", 0, NOP, out_data, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
